pattern_matcher: RTL
====================

PATTERN_MATCHER -- requirements
Module: pattern_matcher

Interface
REQ-001 SHALL have parameter DATA_W, default 3, meaning width of each input symbol (>=1).
REQ-002 SHALL have parameter SEQ_LEN, default 8, meaning number of symbols in the pattern (>=2).
REQ-003 SHALL have parameter PATTERN_INIT, default {101,011,110,110,000,110,101,001} (element 0 in LSBs), meaning reset pattern.
REQ-004 SHALL have parameter CNT_W, default 16, meaning match counter width (used only with MATCH_CNT_EN).
REQ-005 SHALL have port clk  input  1  rising-edge clock; single clock domain.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port data_valid  input  1  qualifies data for one cycle.
REQ-008 SHALL have port data  input  DATA_W  stream symbol.
REQ-009 SHALL have port overlap_en  input  1  1 = overlapping matches allowed.
REQ-010 SHALL have port pat_load  input  1  loads pat_data/pat_mask into the pattern registers.
REQ-011 SHALL have port pat_data  input  SEQ_LEN*DATA_W  element i at bits [i*DATA_W +: DATA_W]; element 0 is the first symbol received.
REQ-012 SHALL have port pat_mask  input  SEQ_LEN  bit i = 1 makes element i don't-care.
REQ-013 SHALL have port sequence_found  output  1  registered one-cycle match pulse.
REQ-014 SHALL have port armed  output  1  history holds SEQ_LEN valid symbols.
REQ-015 SHALL have, only with MATCH_CNT_EN, ports cnt_clr input 1 and match_count output CNT_W.

Function
REQ-016 SHALL capture data into a SEQ_LEN-deep history shift register on each rising edge with data_valid=1; cycles with data_valid=0 leave the history, the fill count and the state unchanged.
REQ-017 SHALL implement a two-state FSM: FILL (fill count < SEQ_LEN) and ARMED; FILL->ARMED when the SEQ_LEN-th valid symbol is captured; ARMED->FILL on pat_load, or on a match with overlap_en=0.
REQ-018 SHALL evaluate a match as: the new symbol plus the previous SEQ_LEN-1 history entries equal the pattern element-by-element, ignoring masked elements, with the count of valid symbols including the new one equal to SEQ_LEN.
REQ-019 SHALL assert sequence_found for exactly one cycle after the clock edge that captured the final matching symbol (latency 1 edge, registered output).
REQ-020 SHALL, with overlap_en=1, allow consecutive-symbol matches (shift-register semantics).
REQ-021 SHALL, with overlap_en=0, clear the fill count on a match so the next match needs SEQ_LEN fresh symbols.
REQ-022 SHALL treat simultaneous pat_load and data_valid as: load wins; the symbol is discarded, the fill count goes to 0, and sequence_found=0 on the next cycle.
REQ-023 SHALL sample overlap_en on each capture edge; a change takes effect from the next captured symbol.
REQ-024 SHALL drive armed = 1 exactly when in state ARMED.

Reset
REQ-025 SHALL, while reset_n=0, asynchronously force sequence_found=0, armed=0, fill count=0, history=0, pattern=PATTERN_INIT, mask=all zero, match_count=0.
REQ-026 SHALL resume capture on the first rising edge after reset_n deasserts; a partial sequence before reset is never completed.

Configuration
REQ-027 SHALL, with MATCH_CNT_EN defined, include a CNT_W-bit match_count that increments on each match, saturates at all-ones, and clears on cnt_clr, with clear winning over a simultaneous match.
REQ-028 SHALL, without MATCH_CNT_EN, omit the cnt_clr and match_count ports and the counter logic; all other behaviour is unchanged.

Structure
REQ-029 SHALL place the FSM state enum (S_FILL, S_ARMED) and the default pattern constant in package pattern_matcher_pkg.
REQ-030 SHALL place the saturating counter in sub-module sat_counter (parameter WIDTH; inputs inc and clr), instantiated only under MATCH_CNT_EN.

Verification
REQ-031 SHALL cover: defaults, after reset, feed 001,101,110,000,110,110,011,101 -> sequence_found=1 for one cycle after the 8th symbol.
REQ-032 SHALL cover: feed 001,101,110,110 -> sequence_found stays 0 and armed=0.
REQ-033 SHALL cover: feed 001,101, pulse reset_n low, then feed 110,000 -> no match and fill count restarts at 0.
REQ-034 SHALL cover: load pattern all 111 with no mask, overlap_en=1, feed ten 111 -> pulses after symbols 8, 9 and 10; repeat with overlap_en=0 -> pulse only after symbol 8, then again after symbol 16.
REQ-035 SHALL cover: default pattern with pat_mask=8'b0000_1000, 4th symbol 111, and data_valid=0 gaps inserted between symbols -> one pulse after the last valid symbol.
REQ-036 SHALL cover, with MATCH_CNT_EN and CNT_W=2: 5 matches -> match_count=3 (saturated); cnt_clr coincident with a match -> 0.

Source files
------------

// File: rtl/pattern_matcher_pkg.sv
// -----------------------------------------------------------------------------
// pattern_matcher_pkg
// Shared definitions for the pattern matcher:
//   state_t          - two-state matcher FSM (S_FILL, S_ARMED)
//   DEFAULT_DATA_W   - default symbol width
//   DEFAULT_SEQ_LEN  - default pattern length
//   DEFAULT_PATTERN  - default reset pattern, element 0 in the LSBs
//                      (001,101,110,000,110,110,011,101 in arrival order)
// -----------------------------------------------------------------------------
package pattern_matcher_pkg;

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_W  = 3;
    localparam int DEFAULT_SEQ_LEN = 8;

    localparam logic [DEFAULT_SEQ_LEN*DEFAULT_DATA_W-1:0] DEFAULT_PATTERN =
        24'b101_011_110_110_000_110_101_001;

endpackage

// File: rtl/pattern_matcher_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear. Clear has priority over inc;
// the count holds at all-ones once reached.
// Ports:
//   clk     in   rising-edge clock
//   reset_n in   asynchronous active-low reset (count -> 0)
//   inc     in   increment request for this cycle
//   clr     in   synchronous clear, wins over inc
//   count   out  WIDTH-bit counter value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pattern_matcher.sv
// -----------------------------------------------------------------------------
// pattern_matcher
// Streams DATA_W-bit symbols into a SEQ_LEN-deep history and pulses
// sequence_found one cycle after the symbol that completes the programmed
// (optionally masked) pattern. Overlapping matches are selectable at run time.
//
// Optional feature: define MATCH_CNT_EN to add a saturating match counter
// (ports cnt_clr / match_count, sub-module sat_counter).
//
// Ports:
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   data_valid     in   qualifies data for one cycle
//   data           in   stream symbol
//   overlap_en     in   1 = overlapping matches allowed
//   pat_load       in   load pat_data/pat_mask; wins over data_valid
//   pat_data       in   pattern, element i at [i*DATA_W +: DATA_W], 0 = oldest
//   pat_mask       in   bit i = 1 makes element i don't-care
//   sequence_found out  registered one-cycle match pulse
//   armed          out  history holds SEQ_LEN valid symbols
//   cnt_clr        in   (MATCH_CNT_EN) clear match_count
//   match_count    out  (MATCH_CNT_EN) saturating match counter
// -----------------------------------------------------------------------------
module pattern_matcher
    import pattern_matcher_pkg::*;
#(
    parameter int                                DATA_W       = DEFAULT_DATA_W,
    parameter int                                SEQ_LEN      = DEFAULT_SEQ_LEN,
    parameter logic [SEQ_LEN*DATA_W-1:0]         PATTERN_INIT = DEFAULT_PATTERN,
    parameter int                                CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      data_valid,
    input  logic [DATA_W-1:0]         data,
    input  logic                      overlap_en,
    input  logic                      pat_load,
    input  logic [SEQ_LEN*DATA_W-1:0] pat_data,
    input  logic [SEQ_LEN-1:0]        pat_mask,
`ifdef MATCH_CNT_EN
    input  logic                      cnt_clr,
    output logic [CNT_W-1:0]          match_count,
`endif
    output logic                      sequence_found,
    output logic                      armed
);

    localparam int PAT_W  = SEQ_LEN * DATA_W;
    localparam int FILL_W = $clog2(SEQ_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SEQ_LEN - 1);

    state_t              state_q, state_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [PAT_W-1:0]    hist_q;
    logic [PAT_W-1:0]    window;
    logic [PAT_W-1:0]    pat_q;
    logic [SEQ_LEN-1:0]  mask_q;
    logic                capture;
    logic                hit;
    logic                match;
    logic                found_p1;

    // A load in the same cycle discards the symbol.
    assign capture = data_valid && !pat_load;

    // Candidate window: the new symbol becomes the newest (highest) element,
    // the oldest history entry drops out. This is also the next history value.
    assign window = {data, hist_q[PAT_W-1:DATA_W]};

    always_comb begin
        hit = 1'b1;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (!mask_q[i] &&
                (window[i*DATA_W +: DATA_W] != pat_q[i*DATA_W +: DATA_W])) begin
                hit = 1'b0;
            end
        end
    end

    // The fill count saturates at SEQ_LEN, so ">= SEQ_LEN-1" means the new
    // symbol makes (or keeps) the window fully populated.
    assign match = capture && hit && (fill_q >= FILL_LAST);

    always_comb begin
        fill_d  = fill_q;
        state_d = state_q;
        if (pat_load) begin
            fill_d  = '0;
            state_d = S_FILL;
        end else if (data_valid) begin
            if (match && !overlap_en) begin
                fill_d  = '0;
                state_d = S_FILL;
            end else begin
                if (fill_q != FILL_FULL) begin
                    fill_d = fill_q + 1'b1;
                end
                if (fill_q >= FILL_LAST) begin
                    state_d = S_ARMED;
                end
            end
        end
    end

    // ---- stage p0 -> p1: capture history, FSM and registered match pulse ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_FILL;
            fill_q   <= '0;
            hist_q   <= '0;
            pat_q    <= PATTERN_INIT;
            mask_q   <= '0;
            found_p1 <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            found_p1 <= match;
            if (pat_load) begin
                pat_q  <= pat_data;
                mask_q <= pat_mask;
            end
            if (capture) begin
                hist_q <= window;
            end
        end
    end

    assign sequence_found = found_p1;
    assign armed          = (state_q == S_ARMED);

`ifdef MATCH_CNT_EN
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_match_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (match),
        .clr     (cnt_clr),
        .count   (match_count)
    );
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule
